// File: rtl/sum_bcd_converter.sv
// sum_bcd_converter: converts the adder's {carry, sum} into three BCD digits by iterative double-dabble
module sum_bcd_converter #(
    parameter int N_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] sum,
    input  logic              carry,
    output logic              busy,
    output logic              done,
    output logic [3:0]        hundreds,
    output logic [3:0]        tens,
    output logic [3:0]        ones
);
    localparam int W  = N_BITS + 1;
    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t        state;
    logic [11:0]   bcd;
    logic [11:0]   bcd_adj;
    logic [W-1:0]  bin;
    logic [CW-1:0] count;
    logic [W+11:0] shifted;
    logic          last;

    // one iteration: correct every nibble >= 5 by +3, then shift the whole {bcd, bin} register left
    always_comb begin
        for (int i = 0; i < 3; i++)
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        shifted = {bcd_adj[10:0], bin, 1'b0};
        last    = (count == CW'(W - 1));
    end

    // control FSM and datapath; digits load only on the completion edge so partial results never show
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hundreds <= 4'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
            bcd      <= 12'd0;
            bin      <= '0;
            count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin   <= {carry, sum};
                        bcd   <= 12'd0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd   <= shifted[W+11:W];
                    bin   <= shifted[W-1:0];
                    count <= count + 1'b1;
                    if (last) begin
                        {hundreds, tens, ones} <= shifted[W+11:W];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sum_bcd_converter.sv
// tb_sum_bcd_converter: randomized and directed checks of the BCD converter against a decimal model
module tb_sum_bcd_converter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       carry = 1'b0;
    logic [7:0] sum = 8'd0;
    logic       busy, done;
    logic [3:0] hundreds, tens, ones;

    logic       start4 = 1'b0;
    logic       carry4 = 1'b0;
    logic [3:0] sum4 = 4'd0;
    logic       busy4, done4;
    logic [3:0] h4, t4, o4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_bcd_converter #(.N_BITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .sum(sum), .carry(carry),
        .busy(busy), .done(done), .hundreds(hundreds), .tens(tens), .ones(ones)
    );

    sum_bcd_converter #(.N_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .sum(sum4), .carry(carry4),
        .busy(busy4), .done(done4), .hundreds(h4), .tens(t4), .ones(o4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // decimal reference: digits packed as hex nibbles {hundreds, tens, ones}
    function automatic logic [31:0] ref_bcd(input int v);
        return 32'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    function automatic logic [31:0] digits();
        return {20'd0, hundreds, tens, ones};
    endfunction

    // counts negedges from the driving negedge until done, plus how many of them saw busy
    task automatic wait_done(output int k, output int nb);
        k = 0;
        nb = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy) nb++;
            if (k == 1) check("done_low_after_accept", {31'd0, done}, 32'd1 - 32'd1);
        end while (!done && k < 30);
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_done4(output int k, output int nb);
        k = 0;
        nb = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy4) nb++;
        end while (!done4 && k < 30);
        check("n4_done_seen", {31'd0, done4}, 32'd1);
    endtask

    task automatic convert_one(input int v);
        int k, nb;
        sum   = v[7:0];
        carry = v[8];
        start = 1'b1;
        wait_done(k, nb);
        start = 1'b0;
        check("latency", k, 10);
        check("busy_cycles", nb, 9);
        check("digits", digits(), ref_bcd(v));
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int k, nb, v, pulses, dc;
        logic [31:0] cap;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_digits", digits(), 32'd0);
        check("n4_reset_busy", {31'd0, busy4}, 32'd0);
        check("n4_reset_digits", {20'd0, h4, t4, o4}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        convert_one(0);
        convert_one(510);

        // full sweep, each start issued in the done cycle of the previous conversion
        start = 1'b1;
        for (int i = 0; i < 512; i++) begin
            sum   = 8'(i);
            carry = i[8];
            wait_done(k, nb);
            check("sweep_spacing", k, 10);
            check("sweep_busy", nb, 9);
            check("sweep_digits", digits(), ref_bcd(i));
        end
        start = 1'b0;
        @(negedge clk);

        // random values with random idle gaps
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            v = int'($urandom_range(0, 511));
            sum   = v[7:0];
            carry = v[8];
            start = 1'b1;
            wait_done(k, nb);
            start = 1'b0;
            check("rand_latency", k, 10);
            check("rand_digits", digits(), ref_bcd(v));
        end
        @(negedge clk);

        // starts during busy are ignored, input changes during conversion are not sampled
        sum = 8'd99;
        carry = 1'b0;
        start = 1'b1;
        pulses = 0;
        dc = 0;
        cap = 32'd0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                dc = c;
                cap = digits();
            end
            sum = 8'd200;
            start = (c == 3 || c == 8);
        end
        start = 1'b0;
        check("ignored_pulses", pulses, 1);
        check("ignored_latency", dc, 10);
        check("ignored_digits", cap, ref_bcd(99));

        // asynchronous reset in the middle of a conversion
        convert_one(123);
        sum = 8'd250;
        carry = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_done", {31'd0, done}, 32'd0);
        check("areset_digits", digits(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("areset_no_done", pulses, 0);
        check("areset_hold", digits(), 32'd0);
        convert_one(77);

        // narrow instance
        sum4 = 4'd15;
        carry4 = 1'b1;
        start4 = 1'b1;
        wait_done4(k, nb);
        start4 = 1'b0;
        check("n4_latency", k, 6);
        check("n4_busy_cycles", nb, 5);
        check("n4_digits", {20'd0, h4, t4, o4}, ref_bcd(31));
        @(negedge clk);
        start4 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 31));
            sum4 = v[3:0];
            carry4 = v[4];
            wait_done4(k, nb);
            check("n4_rand_spacing", k, 6);
            check("n4_rand_digits", {20'd0, h4, t4, o4}, ref_bcd(v));
        end
        start4 = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sum_bcd_converter.md
Name: sum_bcd_converter

Overview:
- Downstream of the calculator's 8-bit adder. Takes the adder's 8-bit sum plus carry-out as one unsigned value (range 0..510).
- Converts the value to three BCD digits (hundreds, tens, ones) for the display/seven-segment stage.
- Iterative shift-and-add-3 (double-dabble) datapath under a small FSM, with a start/busy/done handshake.
- Result registers hold the last conversion until the next one completes.

Parameters:
N_BITS, 8, width of the sum input. The converted value is {carry, sum}, N_BITS+1 bits. Legal range is 1..8; larger values cannot be represented in 3 BCD digits.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a conversion; sampled only in IDLE
sum  input  N_BITS  adder sum output
carry  input  1  adder carry-out; MSB of the converted value
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new digits are presented
hundreds  output  4  BCD hundreds digit (0..5 for N_BITS=8)
tens  output  4  BCD tens digit (0..9)
ones  output  4  BCD ones digit (0..9)

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0, done=0, hundreds=tens=ones=0.
  - Internal shift register and iteration counter cleared.
  - Takes effect immediately, including mid-conversion; the in-flight conversion is discarded and outputs do not change to any partial result.
- States: IDLE, CONVERT.
- IDLE:
  - If start=1 at edge E0: capture {carry,sum} into the binary part of the shift register.
  - Clear the 12-bit BCD part and set counter=0. Go to CONVERT; busy=1 from E0.
  - Inputs are not sampled again during the conversion.
- CONVERT: each edge performs one iteration.
  - Step 1: each BCD nibble >=5 gets +3 (per-nibble 4-bit add, no carry between nibbles). The nibbles are corrected before the shift.
  - Step 2: shift the whole {BCD, binary} register left by 1.
  - Step 3: counter increments.
  - Exactly N_BITS+1 iterations (9 for the default). The final iteration is at edge E(N_BITS+1).
- Completion edge E(N_BITS+1):
  - hundreds/tens/ones are loaded with the post-shift BCD nibbles.
  - busy goes to 0, done goes to 1, state goes to IDLE.
- Latency: start at E0, then valid digits and done visible in the cycle after E9 (N_BITS=8). busy is high for exactly 9 cycles.
- done:
  - High for exactly one cycle.
  - Cleared on the next edge unless that edge is itself a completion edge. This cannot happen at full rate, so done never stays high for 2 consecutive cycles.
- start while busy=1 is ignored, with no queuing.
- start in the done cycle (state already IDLE) is accepted. This gives back-to-back conversions with a throughput of one per N_BITS+2 cycles.
- start held high continuously gives repeated conversions. Each one samples {carry,sum} at its own accept edge.
- Output digits are never X after reset. They change only at completion edges or at reset.
- Arithmetic is unsigned only. No overflow case exists for legal N_BITS.

Test Plan:
- Reset, then start with sum=8'd0, carry=0 -> busy high 9 cycles; done pulse; digits 0,0,0.
- sum=8'd255, carry=1 (value 510) -> after 9 busy cycles: hundreds=5, tens=1, ones=0; done high exactly 1 cycle.
- Sweep all 512 {carry,sum} values, starting each in the done cycle of the previous one -> every result matches a decimal reference model; spacing between accept edges is exactly 10 cycles.
- Start with sum=8'd99, carry=0; pulse start again at cycles 3 and 8 with sum=8'd200 -> extra starts ignored; result 0,9,9; only one done pulse.
- Complete a conversion of 123 (digits 1,2,3); start a conversion of 250; assert reset asynchronously at cycle 4 (between edges) -> outputs go to 0 and busy=0 immediately, with no done pulse. The next conversion of 77 gives 0,7,7 after 9 cycles.
- N_BITS=4 build: sum=4'd15, carry=1 (value 31) -> busy 5 cycles; digits 0,3,1.
